// File: rtl/core_ncache_router.sv
// core_ncache_router: sends each core memory request to either the data cache
// or the uncached bus. A request is uncached when its address falls inside
// the window defined by ncache_base/ncache_mask. A route-tag FIFO records the
// owner of every outstanding request, so responses return to the core in the
// same order the requests were issued.
module core_ncache_router #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ncache_base,
  input  logic [AW-1:0] ncache_mask,
  // core request
  input  logic          req_val,
  output logic          req_rdy,
  input  logic [AW-1:0] req_addr,
  input  logic          req_we,
  input  logic [3:0]    req_be,
  input  logic [DW-1:0] req_wdata,
  // core response
  output logic          rsp_val,
  output logic [DW-1:0] rsp_data,
  // cache port
  output logic          c_req_val,
  input  logic          c_req_rdy,
  output logic [AW-1:0] c_req_addr,
  output logic          c_req_we,
  output logic [3:0]    c_req_be,
  output logic [DW-1:0] c_req_wdata,
  input  logic          c_rsp_val,
  output logic          c_rsp_rdy,
  input  logic [DW-1:0] c_rsp_data,
  // uncached port
  output logic          nc_req_val,
  input  logic          nc_req_rdy,
  output logic [AW-1:0] nc_req_addr,
  output logic          nc_req_we,
  output logic [3:0]    nc_req_be,
  output logic [DW-1:0] nc_req_wdata,
  input  logic          nc_rsp_val,
  output logic          nc_rsp_rdy,
  input  logic [DW-1:0] nc_rsp_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Stored per outstanding request: the owning port, plus whether it was a
  // store, since a store returns zero data to the core.
  typedef struct packed {
    logic we;
    logic nc;
  } tag_t;

  tag_t          tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic          fifo_full;
  logic          fifo_empty;
  logic          nc_hit;
  logic          push;
  logic          pop;
  tag_t          head;
  logic [DW-1:0] owner_data;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // The window is read only at acceptance. Routing of an outstanding request
  // comes from its stored tag, so a later base/mask change does not reroute it.
  assign nc_hit = ((req_addr ^ ncache_base) & ncache_mask) == '0;

  // Request path: pure pass-through. Only the selected port sees valid.
  assign c_req_val    = req_val & ~fifo_full & ~nc_hit;
  assign nc_req_val   = req_val & ~fifo_full &  nc_hit;
  assign c_req_addr   = req_addr;
  assign c_req_we     = req_we;
  assign c_req_be     = req_be;
  assign c_req_wdata  = req_wdata;
  assign nc_req_addr  = req_addr;
  assign nc_req_we    = req_we;
  assign nc_req_be    = req_be;
  assign nc_req_wdata = req_wdata;

  // The full flag comes from the registered count. A downstream ready can
  // never sneak a push into a full FIFO, even in a cycle that also pops.
  assign req_rdy = ~fifo_full & (nc_hit ? nc_req_rdy : c_req_rdy);
  assign push    = req_val & req_rdy;

  // Response path: only the port owning the oldest request may respond.
  // An early response on the other port is held off, not dropped.
  assign head       = tag_mem[rd_ptr];
  assign c_rsp_rdy  = ~fifo_empty & ~head.nc;
  assign nc_rsp_rdy = ~fifo_empty &  head.nc;
  assign pop        = (c_rsp_val & c_rsp_rdy) | (nc_rsp_val & nc_rsp_rdy);
  assign owner_data = head.nc ? nc_rsp_data : c_rsp_data;

  // Tag storage write.
  // NOTE: storage is deliberately not reset; reset empties the FIFO through
  // count and the pointers, so old entries are never read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= '{we: req_we, nc: nc_hit};
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: state uses non-blocking assignments so every register here updates
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered core response: a one-cycle pulse after each downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_val  <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_val  <= pop;
      rsp_data <= (pop && !head.we) ? owner_data : '0;
    end
  end

endmodule
